// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// master: fetch-unit view. slave: memory/decode (environment) view.
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [31:0]           imem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           Instr;
    logic [ADDR_WIDTH-1:0] InstrPC;
    logic [2:0]            Opcode;
    logic                  V;
    logic [2:0]            Funct;
    logic [3:0]            Rd;
    logic [3:0]            Rn;
    logic [3:0]            Rm;
    logic [16:0]           Imm;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid,
        input  instr_ready,
        output Instr, InstrPC, Opcode, V, Funct, Rd, Rn, Rm, Imm
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  Instr, InstrPC, Opcode, V, Funct, Rd, Rn, Rm, Imm
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding req/ack fetch from instruction
// memory, one-entry output register with valid/ready towards decode, and
// PC redirect with squash of an in-flight fetch.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] BranchTarget,
    instruction_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SQUASH = 2'd2,
        ST_FULL   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_addr;
    logic [ADDR_WIDTH-1:0] w_fetch_addr_next;
    logic [ADDR_WIDTH-1:0] r_tgt;
    logic [ADDR_WIDTH-1:0] w_tgt_next;
    logic [31:0]           r_instr;
    logic [31:0]           w_instr_next;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic [ADDR_WIDTH-1:0] w_instr_pc_next;
    logic                  r_valid;
    logic                  w_valid_next;
    logic                  r_req;
    logic                  w_req_next;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_ack;
    logic                  w_unused_target_lsb;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign w_target            = {BranchTarget[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_target_lsb = ^BranchTarget[1:0];

    // An ack only counts while a request is actually outstanding.
    assign w_ack = bus.imem_ack & r_req;

    // Request is a registered decode of the next state, so it drops at once on reset.
    assign w_req_next = (w_state_next == ST_FETCH) || (w_state_next == ST_SQUASH);

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_fetch_addr;
    assign bus.instr_valid = r_valid;
    assign bus.Instr       = r_instr;
    assign bus.InstrPC     = r_instr_pc;
    assign bus.Opcode      = r_instr[31:29];
    assign bus.V           = r_instr[28];
    assign bus.Funct       = r_instr[27:25];
    assign bus.Rd          = r_instr[24:21];
    assign bus.Rn          = r_instr[20:17];
    assign bus.Rm          = r_instr[16:13];
    assign bus.Imm         = r_instr[16:0];

    // Next-state and datapath updates for the fetch FSM.
    always_comb begin
        w_state_next      = r_state;
        w_fetch_addr_next = r_fetch_addr;
        w_tgt_next        = r_tgt;
        w_instr_next      = r_instr;
        w_instr_pc_next   = r_instr_pc;
        w_valid_next      = r_valid;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
                if (PCSrc) begin
                    w_fetch_addr_next = w_target;
                end else begin
                    w_fetch_addr_next = r_fetch_addr;
                end
            end
            ST_FETCH: begin
                if (w_ack && !PCSrc) begin
                    w_instr_next      = bus.imem_rdata;
                    w_instr_pc_next   = r_fetch_addr;
                    w_valid_next      = 1'b1;
                    w_fetch_addr_next = r_fetch_addr + ADDR_WIDTH'(32'd4);
                    w_state_next      = ST_FULL;
                end else if (w_ack) begin
                    // Returned word belongs to the old stream: drop it.
                    w_fetch_addr_next = w_target;
                    w_state_next      = ST_FETCH;
                end else if (PCSrc) begin
                    // Request must stay stable until ack; remember where to go.
                    w_tgt_next   = w_target;
                    w_state_next = ST_SQUASH;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_SQUASH: begin
                if (PCSrc) begin
                    w_tgt_next = w_target;
                end else begin
                    w_tgt_next = r_tgt;
                end
                if (w_ack) begin
                    w_fetch_addr_next = PCSrc ? w_target : r_tgt;
                    w_state_next      = ST_FETCH;
                end else begin
                    w_state_next = ST_SQUASH;
                end
            end
            ST_FULL: begin
                if (PCSrc) begin
                    w_valid_next      = 1'b0;
                    w_fetch_addr_next = w_target;
                    w_state_next      = ST_FETCH;
                end else if (bus.instr_ready) begin
                    w_valid_next = 1'b0;
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_FULL;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_fetch_addr <= RESET_PC;
            r_tgt        <= {ADDR_WIDTH{1'b0}};
            r_instr      <= 32'h0000_0000;
            r_instr_pc   <= {ADDR_WIDTH{1'b0}};
            r_valid      <= 1'b0;
            r_req        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_tgt        <= w_tgt_next;
            r_instr      <= w_instr_next;
            r_instr_pc   <= w_instr_pc_next;
            r_valid      <= w_valid_next;
            r_req        <= w_req_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pcsrc;
    logic [31:0] branch_target;
    int          errors;
    int          checks;

    instruction_fetch_unit_if #(.ADDR_WIDTH(32)) u_if ();

    instruction_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .PCSrc        (pcsrc),
        .BranchTarget (branch_target),
        .bus          (u_if.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2A4A_0000;
        else return 32'hC0DE_0000 ^ a;
    endfunction

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory read data follows the presented address.
    always_comb u_if.imem_rdata = mem_word(u_if.imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pcsrc = 1'b0; branch_target = 32'h0;
        u_if.imem_ack = 1'b0; u_if.instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            u_if.imem_ack = i[0];
            step();
        end
        checks++; if (u_if.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", u_if.imem_req); end
        checks++; if (u_if.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", u_if.instr_valid); end
        checks++; if (u_if.Opcode !== 3'd0 || u_if.Instr !== 32'h0 || u_if.InstrPC !== 32'h0) begin errors++; $display("FAIL rst_out: got op=%0d instr=%h pc=%h want 0", u_if.Opcode, u_if.Instr, u_if.InstrPC); end
        u_if.imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (u_if.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", u_if.imem_req); end
        step();
        checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1/00000000", u_if.imem_req, u_if.imem_addr); end
    endtask

    task automatic test_zero_wait();
        u_if.imem_ack = 1'b1; u_if.instr_ready = 1'b1;
        step();
        checks++; if (u_if.instr_valid !== 1'b1 || u_if.imem_req !== 1'b0) begin errors++; $display("FAIL zw_valid: got valid=%b req=%b want 1/0", u_if.instr_valid, u_if.imem_req); end
        checks++; if (u_if.Opcode !== 3'd1 || u_if.V !== 1'b0 || u_if.Funct !== 3'd5) begin errors++; $display("FAIL zw_fields1: got op=%0d v=%b f=%0d want 1/0/5", u_if.Opcode, u_if.V, u_if.Funct); end
        checks++; if (u_if.Rd !== 4'd2 || u_if.Rn !== 4'd5 || u_if.Rm !== 4'd0 || u_if.Imm !== 17'd0) begin errors++; $display("FAIL zw_fields2: got rd=%0d rn=%0d rm=%0d imm=%h want 2/5/0/0", u_if.Rd, u_if.Rn, u_if.Rm, u_if.Imm); end
        checks++; if (u_if.InstrPC !== 32'h0 || u_if.Instr !== 32'h2A4A_0000) begin errors++; $display("FAIL zw_instr: got pc=%h instr=%h want 0/2a4a0000", u_if.InstrPC, u_if.Instr); end
        step();
        checks++; if (u_if.instr_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h4) begin errors++; $display("FAIL zw_next: got valid=%b req=%b addr=%h want 0/1/4", u_if.instr_valid, u_if.imem_req, u_if.imem_addr); end
        u_if.imem_ack = 1'b0; u_if.instr_ready = 1'b0;
    endtask

    task automatic test_latency_backpressure();
        for (int c = 0; c < 4; c++) begin
            checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h4 || u_if.instr_valid !== 1'b0) begin errors++; $display("FAIL lat_hold%0d: got req=%b addr=%h valid=%b want 1/4/0", c, u_if.imem_req, u_if.imem_addr, u_if.instr_valid); end
            if (c == 3) u_if.imem_ack = 1'b1;
            step();
        end
        u_if.imem_ack = 1'b0;
        checks++; if (u_if.instr_valid !== 1'b1 || u_if.InstrPC !== 32'h4 || u_if.Instr !== 32'hC0DE_0004) begin errors++; $display("FAIL lat_fill: got valid=%b pc=%h instr=%h want 1/4/c0de0004", u_if.instr_valid, u_if.InstrPC, u_if.Instr); end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (u_if.instr_valid !== 1'b1 || u_if.Instr !== 32'hC0DE_0004 || u_if.imem_req !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got valid=%b instr=%h req=%b want 1/c0de0004/0", c, u_if.instr_valid, u_if.Instr, u_if.imem_req); end
        end
        u_if.instr_ready = 1'b1;
        step();
        u_if.instr_ready = 1'b0;
        checks++; if (u_if.instr_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h8) begin errors++; $display("FAIL bp_release: got valid=%b req=%b addr=%h want 0/1/8", u_if.instr_valid, u_if.imem_req, u_if.imem_addr); end
    endtask

    task automatic test_squash();
        pcsrc = 1'b1; branch_target = 32'h0000_0103;
        step();
        pcsrc = 1'b0;
        checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h8) begin errors++; $display("FAIL sq_hold: got req=%b addr=%h want 1/8", u_if.imem_req, u_if.imem_addr); end
        step();
        u_if.imem_ack = 1'b1;
        step();
        checks++; if (u_if.instr_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h100) begin errors++; $display("FAIL sq_redirect: got valid=%b req=%b addr=%h want 0/1/100", u_if.instr_valid, u_if.imem_req, u_if.imem_addr); end
        step();
        u_if.imem_ack = 1'b0;
        checks++; if (u_if.instr_valid !== 1'b1 || u_if.InstrPC !== 32'h100 || u_if.Instr !== 32'hC0DE_0100) begin errors++; $display("FAIL sq_fill: got valid=%b pc=%h instr=%h want 1/100/c0de0100", u_if.instr_valid, u_if.InstrPC, u_if.Instr); end
        u_if.instr_ready = 1'b1;
        step();
        u_if.instr_ready = 1'b0;
        // Second redirect arrives together with the ack of the squashed request.
        pcsrc = 1'b1; branch_target = 32'h0000_0300;
        step();
        branch_target = 32'h0000_0400; u_if.imem_ack = 1'b1;
        step();
        pcsrc = 1'b0; u_if.imem_ack = 1'b0;
        checks++; if (u_if.instr_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h400) begin errors++; $display("FAIL sq_latest: got valid=%b req=%b addr=%h want 0/1/400", u_if.instr_valid, u_if.imem_req, u_if.imem_addr); end
    endtask

    task automatic test_same_cycle();
        u_if.imem_ack = 1'b1; pcsrc = 1'b1; branch_target = 32'h0000_0500;
        step();
        pcsrc = 1'b0;
        checks++; if (u_if.instr_valid !== 1'b0 || u_if.imem_addr !== 32'h500) begin errors++; $display("FAIL sc_ack_redirect: got valid=%b addr=%h want 0/500", u_if.instr_valid, u_if.imem_addr); end
        step();
        u_if.imem_ack = 1'b0;
        checks++; if (u_if.instr_valid !== 1'b1 || u_if.InstrPC !== 32'h500) begin errors++; $display("FAIL sc_fill: got valid=%b pc=%h want 1/500", u_if.instr_valid, u_if.InstrPC); end
        pcsrc = 1'b1; branch_target = 32'h0000_0600; u_if.instr_ready = 1'b1;
        step();
        pcsrc = 1'b0; u_if.instr_ready = 1'b0;
        checks++; if (u_if.instr_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h600) begin errors++; $display("FAIL sc_ready_redirect: got valid=%b req=%b addr=%h want 0/1/600", u_if.instr_valid, u_if.imem_req, u_if.imem_addr); end
    endtask

    task automatic test_wrap();
        u_if.imem_ack = 1'b1; pcsrc = 1'b1; branch_target = 32'hFFFF_FFFE;
        step();
        pcsrc = 1'b0;
        checks++; if (u_if.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align: got addr=%h want fffffffc", u_if.imem_addr); end
        step();
        u_if.imem_ack = 1'b0;
        checks++; if (u_if.instr_valid !== 1'b1 || u_if.InstrPC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fill: got valid=%b pc=%h want 1/fffffffc", u_if.instr_valid, u_if.InstrPC); end
        u_if.instr_ready = 1'b1;
        step();
        u_if.instr_ready = 1'b0;
        checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", u_if.imem_req, u_if.imem_addr); end
    endtask

    task automatic test_async_reset();
        checks++; if (u_if.imem_req !== 1'b1) begin errors++; $display("FAIL ar_pre: got req=%b want 1", u_if.imem_req); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (u_if.imem_req !== 1'b0 || u_if.instr_valid !== 1'b0) begin errors++; $display("FAIL ar_drop: got req=%b valid=%b want 0/0", u_if.imem_req, u_if.instr_valid); end
        step();
        u_if.imem_ack = 1'b1;
        step();
        // Release with a stray ack still high and a redirect during IDLE.
        rst = 1'b1; pcsrc = 1'b1; branch_target = 32'h0000_0080;
        step();
        pcsrc = 1'b0; u_if.imem_ack = 1'b0;
        checks++; if (u_if.instr_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h80) begin errors++; $display("FAIL ar_release: got valid=%b req=%b addr=%h want 0/1/80", u_if.instr_valid, u_if.imem_req, u_if.imem_addr); end
    endtask

    // Test sequence.
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_zero_wait();
        test_latency_backpressure();
        test_squash();
        test_same_cycle();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
